// File: rtl/act_led_ctrl_if.sv
// Bundles the SGPIO activity inputs, register controls and LED/status outputs of act_led_ctrl.
// The master side drives the stimulus; the slave side is the LED controller.
interface act_led_ctrl_if;
  logic [35:0] SGPIO_ACT1;
  logic [35:0] SGPIO_ACT2;
  logic        SGPIO_LD1;
  logic        SGPIO_LD2;
  logic [7:0]  CTRL;
  logic        LAMP_TEST_REQ;
  logic [71:0] ACT_LED_L;
  logic [1:0]  SGPIO_FAIL;
  logic        LAMP_TEST_BUSY;

  modport master (
    output SGPIO_ACT1, SGPIO_ACT2, SGPIO_LD1, SGPIO_LD2, CTRL, LAMP_TEST_REQ,
    input  ACT_LED_L, SGPIO_FAIL, LAMP_TEST_BUSY
  );

  modport slave (
    input  SGPIO_ACT1, SGPIO_ACT2, SGPIO_LD1, SGPIO_LD2, CTRL, LAMP_TEST_REQ,
    output ACT_LED_L, SGPIO_FAIL, LAMP_TEST_BUSY
  );
endinterface

// File: rtl/act_led_ctrl.sv
// 72-drive activity LED controller: SGPIO pass-through with per-channel watchdog,
// per-channel force/blink modes, and a lamp-test sequencer that overrides everything.
module act_led_ctrl #(
  parameter int unsigned TICK_DIV   = 25000,
  parameter int unsigned TIMEOUT_MS = 100,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned STEP_MS    = 500,
  parameter int unsigned WALK_MS    = 20
) (
  input logic         SYSCLK,
  input logic         RESET_N,
  act_led_ctrl_if.slave sgpio
);

  localparam int unsigned TICK_W  = $clog2(TICK_DIV + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);
  localparam int unsigned TMR_W   = $clog2(STEP_MS + WALK_MS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ALL_ON  = 2'd1;
  localparam logic [1:0] S_ALL_OFF = 2'd2;
  localparam logic [1:0] S_WALK    = 2'd3;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic [2:0]         r_ld1_sync;
  logic [2:0]         r_ld2_sync;
  logic [1:0]         w_ld_edge;
  logic [WD_W-1:0]    r_wd_cnt  [2];
  logic [WD_W-1:0]    w_wd_next [2];
  logic [1:0]         r_fail;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_next;
  logic [6:0]         r_walk_idx;
  logic [6:0]         w_walk_next;
  logic [71:0]        w_led;
  logic [71:0]        r_led;
  logic               r_busy;
  logic               w_ctrl_unused;

  assign w_ctrl_unused = ^sgpio.CTRL[6:4];

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Stage 2 is the synchronized LD; stage 3 is its previous value for edge detect.
  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      r_ld1_sync <= '0;
      r_ld2_sync <= '0;
    end else begin
      r_ld1_sync <= {r_ld1_sync[1:0], sgpio.SGPIO_LD1};
      r_ld2_sync <= {r_ld2_sync[1:0], sgpio.SGPIO_LD2};
    end
  end

  assign w_ld_edge[0] = r_ld1_sync[1] & ~r_ld1_sync[2];
  assign w_ld_edge[1] = r_ld2_sync[1] & ~r_ld2_sync[2];

  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      w_wd_next[n] = r_wd_cnt[n];
      if (w_ld_edge[n]) w_wd_next[n] = '0;
      else if (w_tick && (r_wd_cnt[n] != WD_W'(TIMEOUT_MS))) w_wd_next[n] = r_wd_cnt[n] + 1'b1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (!RESET_N) begin
        r_wd_cnt[n] <= '0;
        r_fail[n]   <= 1'b0;
      end else begin
        r_wd_cnt[n] <= w_wd_next[n];
        r_fail[n]   <= (w_wd_next[n] == WD_W'(TIMEOUT_MS));
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_walk_next  = r_walk_idx;
    case (r_state)
      S_IDLE: if (sgpio.LAMP_TEST_REQ && !sgpio.CTRL[7]) begin
        w_state_next = S_ALL_ON;
        w_timer_next = '0;
      end
      S_ALL_ON: if (w_tick) begin
        if (r_timer == TMR_W'(STEP_MS - 1)) begin
          w_state_next = S_ALL_OFF;
          w_timer_next = '0;
        end else w_timer_next = r_timer + 1'b1;
      end
      S_ALL_OFF: if (w_tick) begin
        if (r_timer == TMR_W'(STEP_MS - 1)) begin
          w_state_next = S_WALK;
          w_timer_next = '0;
          w_walk_next  = '0;
        end else w_timer_next = r_timer + 1'b1;
      end
      default: if (w_tick) begin
        if (r_timer == TMR_W'(WALK_MS - 1)) begin
          w_timer_next = '0;
          if (r_walk_idx == 7'd71) w_state_next = S_IDLE;
          else w_walk_next = r_walk_idx + 1'b1;
        end else w_timer_next = r_timer + 1'b1;
      end
    endcase
    if ((r_state != S_IDLE) && sgpio.CTRL[7]) begin
      w_state_next = S_IDLE;
      w_timer_next = '0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_walk_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_walk_idx <= w_walk_next;
    end
  end

  // Drive d = 12g+k: even groups come from ch1, odd groups from ch2, bit 12*(g/2)+k.
  always_comb begin
    w_led = '1;
    for (int unsigned d = 0; d < 72; d++) begin
      case (((d / 12) % 2) == 1 ? sgpio.CTRL[3:2] : sgpio.CTRL[1:0])
        2'b00:   w_led[d] = ((d / 12) % 2) == 1
                          ? (r_fail[1] | sgpio.SGPIO_ACT2[12 * (d / 24) + d % 12])
                          : (r_fail[0] | sgpio.SGPIO_ACT1[12 * (d / 24) + d % 12]);
        2'b01:   w_led[d] = 1'b0;
        2'b10:   w_led[d] = 1'b1;
        default: w_led[d] = ~r_blink;
      endcase
      if (r_state == S_ALL_ON)  w_led[d] = 1'b0;
      if (r_state == S_ALL_OFF) w_led[d] = 1'b1;
      if (r_state == S_WALK)    w_led[d] = (r_walk_idx != 7'(d));
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      r_led  <= '1;
      r_busy <= 1'b0;
    end else begin
      r_led  <= w_led;
      r_busy <= (w_state_next != S_IDLE);
    end
  end

  assign sgpio.ACT_LED_L      = r_led;
  assign sgpio.SGPIO_FAIL     = r_fail;
  assign sgpio.LAMP_TEST_BUSY = r_busy;

endmodule

// File: tb/tb_act_led_ctrl.sv
// Randomized bench for act_led_ctrl, checked every cycle against a tick-counting reference model.
module tb_act_led_ctrl;
  localparam int TD = 4, TO = 5, BL = 2, ST = 3, WK = 1;

  logic SYSCLK = 1'b0;
  logic RESET_N;
  act_led_ctrl_if bus ();

  always #5 SYSCLK = ~SYSCLK;

  act_led_ctrl #(.TICK_DIV(TD), .TIMEOUT_MS(TO), .BLINK_MS(BL), .STEP_MS(ST), .WALK_MS(WK)) dut (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .sgpio   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: counts of cycles/ticks, LD sample history, test progress in ticks.
  int          m_cyc;
  logic [3:0]  m_ldh [2];
  int          m_ticks_since_ld [2];
  logic [1:0]  m_fail;
  int          m_blink_ticks;
  bit          m_test_on;
  int          m_test_ticks;
  logic [71:0] m_led;
  logic        m_busy;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          tick;
    bit          edge_n [2];
    logic [71:0] led;
    int          ch, b, n, idx;
    logic [1:0]  mode;
    logic        act;
    if (!RESET_N) begin
      m_cyc = 0;
      m_ldh[0] = '0; m_ldh[1] = '0;
      m_ticks_since_ld[0] = 0; m_ticks_since_ld[1] = 0;
      m_fail = 2'b00;
      m_blink_ticks = 0;
      m_test_on = 0;
      m_test_ticks = 0;
      m_led = '1;
      m_busy = 1'b0;
      return;
    end
    tick = (m_cyc % TD) == TD - 1;
    m_cyc++;
    for (int c = 0; c < 2; c++) edge_n[c] = m_ldh[c][1] && !m_ldh[c][2];
    m_ldh[0] = {m_ldh[0][2:0], bus.SGPIO_LD1};
    m_ldh[1] = {m_ldh[1][2:0], bus.SGPIO_LD2};

    led = '1;
    if (m_test_on) begin
      n = m_test_ticks;
      if (n < ST) led = '0;
      else if (n < 2 * ST) led = '1;
      else begin
        idx = (n - 2 * ST) / WK;
        led[idx] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 72; d++) begin
        ch = (d / 12) % 2;
        b  = 12 * ((d / 12) / 2) + d % 12;
        mode = ch ? bus.CTRL[3:2] : bus.CTRL[1:0];
        act  = ch ? bus.SGPIO_ACT2[b] : bus.SGPIO_ACT1[b];
        case (mode)
          2'b00: led[d] = m_fail[ch] ? 1'b1 : act;
          2'b01: led[d] = 1'b0;
          2'b10: led[d] = 1'b1;
          default: led[d] = ((m_blink_ticks / BL) % 2) == 0;
        endcase
      end
    end
    m_led = led;

    for (int c = 0; c < 2; c++) begin
      if (edge_n[c]) m_ticks_since_ld[c] = 0;
      else if (tick && m_ticks_since_ld[c] < TO) m_ticks_since_ld[c]++;
      m_fail[c] = m_ticks_since_ld[c] >= TO;
    end
    if (tick) m_blink_ticks++;

    if (m_test_on) begin
      if (bus.CTRL[7]) m_test_on = 0;
      else if (tick) begin
        m_test_ticks++;
        if (m_test_ticks >= 2 * ST + 72 * WK) m_test_on = 0;
      end
    end else if (bus.LAMP_TEST_REQ && !bus.CTRL[7]) begin
      m_test_on = 1;
      m_test_ticks = 0;
    end
    m_busy = m_test_on;
  endtask

  // Inputs are set at the falling edge before calling; outputs checked at the next falling edge.
  task automatic cycle();
    @(posedge SYSCLK);
    model_step();
    @(negedge SYSCLK);
    check("ACT_LED_L", bus.ACT_LED_L, m_led);
    check("SGPIO_FAIL", 72'(bus.SGPIO_FAIL), 72'(m_fail));
    check("LAMP_TEST_BUSY", 72'(bus.LAMP_TEST_BUSY), 72'(m_busy));
  endtask

  task automatic rand_act();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    bus.SGPIO_ACT1 = r[35:0];
    r = {$urandom(), $urandom()};
    bus.SGPIO_ACT2 = r[35:0];
  endtask

  int p1, p2, len;
  logic [7:0] base_ctrl;

  initial begin
    RESET_N = 1'b0;
    bus.SGPIO_LD1 = 1'b0; bus.SGPIO_LD2 = 1'b0;
    bus.CTRL = 8'h00; bus.LAMP_TEST_REQ = 1'b0;
    rand_act();
    repeat (3) cycle();
    RESET_N = 1'b1;

    // Random segments: per-channel LD period (0 = stalled), random modes, sporadic req/abort/reset.
    for (int seg = 0; seg < 30; seg++) begin
      p1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 8));
      p2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 8));
      base_ctrl = 8'($urandom_range(0, 127));
      len = int'($urandom_range(20, 120));
      for (int i = 0; i < len; i++) begin
        if (p1 != 0 && i % p1 == 0) bus.SGPIO_LD1 = ~bus.SGPIO_LD1;
        if (p2 != 0 && i % p2 == 0) bus.SGPIO_LD2 = ~bus.SGPIO_LD2;
        if ($urandom_range(0, 3) == 0) rand_act();
        if ($urandom_range(0, 40) == 0) base_ctrl[3:0] = 4'($urandom_range(0, 15));
        bus.CTRL = base_ctrl;
        if ($urandom_range(0, 150) == 0) bus.CTRL[7] = 1'b1;
        bus.LAMP_TEST_REQ = ($urandom_range(0, 60) == 0);
        RESET_N = ($urandom_range(0, 400) != 0);
        cycle();
      end
    end

    // Complete lamp test, then a request held off by the abort bit, then reset during ALL_ON.
    RESET_N = 1'b1; bus.CTRL = 8'h80; bus.LAMP_TEST_REQ = 1'b0;
    cycle();
    bus.CTRL = 8'h00; bus.LAMP_TEST_REQ = 1'b1;
    cycle();
    bus.LAMP_TEST_REQ = 1'b0;
    for (int i = 0; i < 330; i++) begin
      if (i % 4 == 0) bus.SGPIO_LD1 = ~bus.SGPIO_LD1;
      if ($urandom_range(0, 3) == 0) rand_act();
      cycle();
    end
    bus.CTRL = 8'h80; bus.LAMP_TEST_REQ = 1'b1;
    repeat (3) cycle();
    bus.CTRL = 8'h0D; bus.LAMP_TEST_REQ = 1'b0;
    repeat (20) cycle();
    bus.LAMP_TEST_REQ = 1'b1;
    cycle();
    bus.LAMP_TEST_REQ = 1'b0;
    repeat (5) cycle();
    RESET_N = 1'b0;
    cycle();
    RESET_N = 1'b1;
    repeat (40) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
